// File: rtl/water_pkg.sv
// Shared definitions for the water level decoder: level codes, segment patterns,
// alarm FSM state encodings and the display decode helpers.
package water_pkg;

    localparam logic [1:0] LVL_CRITICAL = 2'b00;
    localparam logic [1:0] LVL_LOW      = 2'b01;
    localparam logic [1:0] LVL_MID      = 2'b10;
    localparam logic [1:0] LVL_HIGH     = 2'b11;

    // Active-high segments, bit6..bit0 = a..g
    localparam logic [6:0] SEG_ZERO  = 7'b1111110;
    localparam logic [6:0] SEG_ONE   = 7'b0110000;
    localparam logic [6:0] SEG_TWO   = 7'b1101101;
    localparam logic [6:0] SEG_THREE = 7'b1111001;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    typedef enum logic [1:0] {
        ALARM_IDLE      = 2'd0,
        ALARM_BLINK_ON  = 2'd1,
        ALARM_BLINK_OFF = 2'd2,
        ALARM_LATCHED   = 2'd3
    } alarm_state_t;

    function automatic logic [6:0] seg_decode(input logic [1:0] lvl, input logic valid);
        logic [6:0] seg;
        seg = SEG_DASH;
        if (valid) begin
            case (lvl)
                LVL_CRITICAL: seg = SEG_ZERO;
                LVL_LOW:      seg = SEG_ONE;
                LVL_MID:      seg = SEG_TWO;
                default:      seg = SEG_THREE;
            endcase
        end
        return seg;
    endfunction

    function automatic logic [2:0] leds_decode(input logic [1:0] lvl, input logic valid);
        logic [2:0] leds;
        leds = 3'b000;
        if (valid) begin
            case (lvl)
                LVL_CRITICAL: leds = 3'b000;
                LVL_LOW:      leds = 3'b001;
                LVL_MID:      leds = 3'b011;
                default:      leds = 3'b111;
            endcase
        end
        return leds;
    endfunction

endpackage

// File: rtl/level_debouncer.sv
// Accepts a new level once STABLE_CYCLES consecutive identical samples are seen;
// pulses level_changed for one cycle after each accepted update.
module level_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned WIDTH         = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] level,
    output logic             level_valid,
    output logic             level_changed
);

    localparam logic [7:0] LAST_BEFORE_ACCEPT = 8'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] candidate;
    logic [7:0]       count;

    always_ff @(posedge clk) begin
        if (reset) begin
            candidate     <= '0;
            count         <= '0;
            level         <= '0;
            level_valid   <= 1'b0;
            level_changed <= 1'b0;
        end else begin
            level_changed <= 1'b0;
            if (sample != candidate) begin
                candidate <= sample;
                count     <= 8'd1;
            end else begin
                if (count != 8'hFF) begin
                    count <= count + 8'd1;
                end
                // This edge takes the STABLE_CYCLES-th identical sample
                if (count == LAST_BEFORE_ACCEPT && (candidate != level || !level_valid)) begin
                    level         <= candidate;
                    level_valid   <= 1'b1;
                    level_changed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/water_decoder.sv
// Water level decoder: debounced level, seven-segment/bar-graph display and a
// blinking critical-level alarm. Define WATER_DECODER_ALARM_LATCH_EN to latch the alarm until acknowledged.
module water_decoder
    import water_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned BLINK_HALF    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] encoded_water,
    input  logic       alarm_ack,
    output logic [1:0] level,
    output logic       level_valid,
    output logic       level_changed,
    output logic [6:0] segments,
    output logic [2:0] level_leds,
    output logic       alarm
);

    localparam logic [23:0] HALF_LAST = 24'(BLINK_HALF - 1);

    alarm_state_t alarm_state, alarm_state_next;
    logic [23:0]  blink_cnt, blink_cnt_next;
    logic         critical;

    level_debouncer #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .WIDTH        (2)
    ) u_debouncer (
        .clk          (clk),
        .reset        (reset),
        .sample       (encoded_water),
        .level        (level),
        .level_valid  (level_valid),
        .level_changed(level_changed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            segments <= SEG_DASH;
        end else begin
            segments <= seg_decode(level, level_valid);
        end
    end

    assign level_leds = leds_decode(level, level_valid);
    assign critical   = level_valid && (level == LVL_CRITICAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_state <= ALARM_IDLE;
            blink_cnt   <= '0;
        end else begin
            alarm_state <= alarm_state_next;
            blink_cnt   <= blink_cnt_next;
        end
    end

    always_comb begin
        alarm_state_next = alarm_state;
        blink_cnt_next   = blink_cnt;
        case (alarm_state)
            ALARM_IDLE: begin
                if (critical) begin
                    alarm_state_next = ALARM_BLINK_ON;
                    blink_cnt_next   = '0;
                end
            end
            ALARM_BLINK_ON, ALARM_BLINK_OFF: begin
                if (!critical) begin
`ifdef WATER_DECODER_ALARM_LATCH_EN
                    alarm_state_next = ALARM_LATCHED;
`else
                    alarm_state_next = ALARM_IDLE;
`endif
                    blink_cnt_next   = '0;
                end else if (blink_cnt == HALF_LAST) begin
                    alarm_state_next = (alarm_state == ALARM_BLINK_ON) ? ALARM_BLINK_OFF
                                                                       : ALARM_BLINK_ON;
                    blink_cnt_next   = '0;
                end else begin
                    blink_cnt_next = blink_cnt + 24'd1;
                end
            end
`ifdef WATER_DECODER_ALARM_LATCH_EN
            ALARM_LATCHED: begin
                // Acknowledge only clears once the level has left critical
                if (critical) begin
                    alarm_state_next = ALARM_BLINK_ON;
                    blink_cnt_next   = '0;
                end else if (alarm_ack) begin
                    alarm_state_next = ALARM_IDLE;
                end
            end
`endif
            default: begin
                alarm_state_next = ALARM_IDLE;
                blink_cnt_next   = '0;
            end
        endcase
    end

`ifndef WATER_DECODER_ALARM_LATCH_EN
    logic unused_alarm_ack;
    assign unused_alarm_ack = alarm_ack;
`endif

    assign alarm = (alarm_state == ALARM_BLINK_ON) || (alarm_state == ALARM_LATCHED);

endmodule

// File: doc/water_decoder.md
WATER_DECODER -- requirements
Module: water_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive identical samples needed to accept a new level; legal range 2..255.
REQ-002 The block SHALL have parameter BLINK_HALF, default 8, giving the alarm blink half-period in clk cycles; legal range 1..2^24-1.
REQ-003 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port encoded_water, input, 2 bits: raw level code; 00 critical, 01 low, 10 mid, 11 high.
REQ-006 Port alarm_ack, input, 1 bit: operator acknowledge, level-sampled.
REQ-007 Port level, output, 2 bits: debounced level code.
REQ-008 Port level_valid, output, 1 bit: high once a first level has been accepted.
REQ-009 Port level_changed, output, 1 bit: one-cycle pulse on each accepted level update.
REQ-010 Port segments, output, 7 bits: seven-segment pattern, active-high, bit6..bit0 = a..g.
REQ-011 Port level_leds, output, 3 bits: bar-graph LEDs.
REQ-012 Port alarm, output, 1 bit: critical-level alarm drive.

Function
REQ-013 Debounce: candidate register plus counter; a sample equal to candidate increments the counter (saturating); a differing sample loads candidate and sets the counter to 1.
REQ-014 On the edge that takes the STABLE_CYCLES-th consecutive identical sample, if candidate differs from level or level_valid is 0, level SHALL load candidate, level_valid SHALL set, and level_changed SHALL be high for the following cycle only.
REQ-015 A differing sample arriving on the edge that would be sample STABLE_CYCLES SHALL restart counting; no update.
REQ-016 Stable input equal to the current level SHALL produce no level_changed pulse.
REQ-017 segments SHALL be registered from level: 00->1111110 ("0"), 01->0110000 ("1"), 10->1101101 ("2"), 11->1111001 ("3"); 0000001 ("-") while level_valid is 0.
REQ-018 level_leds SHALL be: 00->000, 01->001, 10->011, 11->111; 000 while level_valid is 0.
REQ-019 Alarm FSM states: IDLE, BLINK_ON, BLINK_OFF, plus LATCHED when the feature in REQ-025 is compiled in.
REQ-020 IDLE->BLINK_ON when level_valid and level==00; BLINK_ON<->BLINK_OFF every BLINK_HALF cycles; alarm=1 only in BLINK_ON and LATCHED.
REQ-021 Leaving critical (level!=00) from BLINK_ON/BLINK_OFF SHALL go to IDLE next edge when the feature is compiled out.
REQ-022 Re-entering critical SHALL restart blinking at BLINK_ON with a fresh half-period count.

Reset
REQ-023 On reset: level=00, level_valid=0, level_changed=0, segments=0000001, level_leds=000, alarm=0, FSM=IDLE, debounce counter=0, blink counter=0.
REQ-024 Reset asserted mid-operation (including mid-blink or mid-debounce) SHALL take precedence over all other updates on that edge.

Configuration
REQ-025 Macro WATER_DECODER_ALARM_LATCH_EN defined: leaving critical from BLINK_ON/BLINK_OFF SHALL go to LATCHED (alarm steady 1) until alarm_ack=1 is sampled, then IDLE; re-entering critical while LATCHED SHALL go to BLINK_ON; alarm_ack while critical is ignored.
REQ-026 Macro undefined: no LATCHED state, alarm_ack ignored, REQ-021 applies.

Structure
REQ-027 A shared package/include water_pkg SHALL hold the level codes (LVL_CRITICAL, LVL_LOW, LVL_MID, LVL_HIGH), segment patterns and alarm FSM state encodings.
REQ-028 Debounce logic SHALL be a sub-module level_debouncer (params STABLE_CYCLES, width 2); decode tables and alarm FSM live in water_decoder.

Verification
REQ-029 Reset, then encoded_water=11 held 4 cycles -> level=11, level_valid=1, segments=1111001, level_leds=111, single level_changed pulse.
REQ-030 From level 11, drive 10,10,10,01,10,10,10,10 -> no update until the fourth consecutive 10; exactly one level_changed pulse; level=10.
REQ-031 Drive 00 stable 4 cycles -> alarm high 8 cycles, low 8, high 8; level_leds=000, segments=1111110.
REQ-032 During blinking drive 01 stable 4 cycles -> macro off: alarm=0 from next cycle; macro on: alarm steady 1 until alarm_ack pulse, then 0.
REQ-033 Assert reset for one cycle in the middle of BLINK_ON -> next cycle all outputs at REQ-023 values; 00 held 4 more cycles restarts alarm at BLINK_ON.
